// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, mode constants and request-entry format for the UART TX path
package uart_pkg;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;
    localparam logic MODE_WORD = 1'b1;
    localparam logic MODE_BYTE = 1'b0;
    localparam int CLKS_PER_BIT_DEFAULT = 868;
    localparam int ENTRY_W = 33;
    typedef logic [ENTRY_W-1:0] entry_t;
    // A queue entry is {mode, payload}; byte requests carry the byte zero-extended
    function automatic entry_t pack_req(input logic mode, input logic [31:0] word, input logic [7:0] data);
        return {mode, (mode == MODE_BYTE) ? {24'h0, data} : word};
    endfunction
endpackage

// File: rtl/uart_tx_req_fifo.sv
// uart_tx_req_fifo: synchronous request FIFO using extra-bit pointers for full/empty
module uart_tx_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic do_push, do_pop;
    assign empty = wr_ptr_q == rd_ptr_q;
    assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout = mem_q[rd_ptr_q[AW-1:0]];
    // a push into a full queue is still taken when the same edge pops the head
    always_comb begin
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end
    // pointer registers; they alone define which slots hold valid data
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
    // payload storage needs no reset
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: queues byte/word send requests and emits them as 8N1 UART frames
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int QUEUE_DEPTH  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        i_mode_select,
    input  logic [31:0] i_word,
    input  logic [7:0]  i_byte,
    output logic        o_serial,
    output logic        o_done,
    output logic        o_busy,
    output logic        o_overflow
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    state_t state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0] bit_q, bit_d;
    logic [1:0] byte_idx_q, byte_idx_d;
    logic [1:0] last_q, last_d;
    logic [23:0] rest_q, rest_d;
    logic [7:0] shift_q, shift_d;
    logic serial_q, serial_d, done_q, done_d, ovf_q, ovf_d;
    logic fifo_pop, fifo_full, fifo_empty, baud_end, head_word;
    entry_t head;
    uart_tx_req_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(enable),
        .pop(fifo_pop),
        .din(pack_req(i_mode_select, i_word, i_byte)),
        .dout(head),
        .full(fifo_full),
        .empty(fifo_empty)
    );
    assign fifo_pop = state_q == S_LOAD;
    assign baud_end = baud_q == BAUD_LAST;
    assign head_word = head[32] == MODE_WORD;
    assign o_serial = serial_q;
    assign o_done = done_q;
    assign o_overflow = ovf_q;
    assign o_busy = !fifo_empty || (state_q != S_IDLE);
    // next-state logic: the current byte shifts out LSB first, later word bytes wait in rest_q
    always_comb begin
        state_d = state_q;
        baud_d = baud_q;
        bit_d = bit_q;
        byte_idx_d = byte_idx_q;
        last_d = last_q;
        rest_d = rest_q;
        shift_d = shift_q;
        serial_d = serial_q;
        done_d = 1'b0;
        ovf_d = enable && fifo_full && !fifo_pop;
        if (state_q inside {S_START, S_DATA, S_STOP}) baud_d = baud_end ? '0 : baud_q + BW'(1);
        case (state_q)
            S_IDLE: state_d = fifo_empty ? S_IDLE : S_LOAD;
            S_LOAD: begin
                state_d = S_START;
                serial_d = 1'b0;
                baud_d = '0;
                byte_idx_d = '0;
                last_d = head_word ? 2'd3 : 2'd0;
                rest_d = head[23:0];
                shift_d = head_word ? head[31:24] : head[7:0];
            end
            S_START: if (baud_end) begin
                state_d = S_DATA;
                bit_d = '0;
                serial_d = shift_q[0];
            end
            S_DATA: if (baud_end) begin
                state_d = (bit_q == 3'd7) ? S_STOP : S_DATA;
                bit_d = bit_q + 3'd1;
                shift_d = shift_q >> 1;
                serial_d = (bit_q == 3'd7) ? 1'b1 : shift_q[1];
            end
            S_STOP: if (baud_end) begin
                state_d = (byte_idx_q == last_q) ? S_IDLE : S_START;
                done_d = byte_idx_q == last_q;
                serial_d = byte_idx_q == last_q;
                byte_idx_d = byte_idx_q + 2'd1;
                shift_d = rest_q[23:16];
                rest_d = {rest_q[15:0], 8'h00};
            end
            default: state_d = S_IDLE;
        endcase
    end
    // FSM, datapath and registered outputs; reset idles the line high
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q <= '0;
            bit_q <= '0;
            byte_idx_q <= '0;
            last_q <= '0;
            rest_q <= '0;
            shift_q <= '0;
            serial_q <= 1'b1;
            done_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q <= baud_d;
            bit_q <= bit_d;
            byte_idx_q <= byte_idx_d;
            last_q <= last_d;
            rest_q <= rest_d;
            shift_q <= shift_d;
            serial_q <= serial_d;
            done_q <= done_d;
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: randomized scoreboard bench with a timing-level model of the UART transmitter
module tb_uart_tx_serializer;
    import uart_pkg::*;
    localparam int CPB = 4;
    localparam int QD = 4;
    localparam int FRAME = 10 * CPB;
    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, i_mode_select = 1'b0;
    logic [31:0] i_word = '0;
    logic [7:0] i_byte = '0;
    logic o_serial, o_done, o_busy, o_overflow;
    int edge_n = 0, n_cmp = 0, n_err = 0, rst_epoch = 0, last_end = -1000;
    typedef struct {int s; logic [7:0] b;} rx_t;
    rx_t exp_rx[$];
    int exp_done[$], exp_ovf[$], acc_pop[$];
    int rx_s, rx_ep, tgt, gap;
    logic [7:0] rx_d;
    logic rx_start, rx_stop;
    rx_t rx_e;

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .QUEUE_DEPTH(QD)) dut (
        .clock(clk),
        .reset(rst),
        .enable(enable),
        .i_mode_select(i_mode_select),
        .i_word(i_word),
        .i_byte(i_byte),
        .o_serial(o_serial),
        .o_done(o_done),
        .o_busy(o_busy),
        .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, got, want, edge_n);
        end
    endfunction

    // Reference model: a request sampled at edge c starts its first frame at max(c, end of previous) + 2;
    // the queue holds requests whose start edge has not passed yet.
    task automatic send(input logic m, input logic [31:0] w, input logic [7:0] b);
        int c, occ, p, nb;
        bit pop_now;
        rx_t e;
        @(negedge clk);
        enable = 1'b1;
        i_mode_select = m;
        i_word = w;
        i_byte = b;
        c = edge_n + 1;
        occ = 0;
        pop_now = 0;
        foreach (acc_pop[i]) begin
            if (acc_pop[i] >= c) occ++;
            if (acc_pop[i] == c) pop_now = 1;
        end
        if (occ < QD || pop_now) begin
            p = ((c > last_end) ? c : last_end) + 2;
            nb = m ? 4 : 1;
            for (int k = 0; k < nb; k++) begin
                e.s = p + FRAME * k;
                e.b = m ? w[31 - 8 * k -: 8] : b;
                exp_rx.push_back(e);
            end
            last_end = p + FRAME * nb;
            exp_done.push_back(last_end);
            acc_pop.push_back(p);
        end else exp_ovf.push_back(c);
    endtask

    task automatic idle_en();
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic model_reset();
        exp_rx.delete();
        exp_done.delete();
        exp_ovf.delete();
        acc_pop.delete();
        last_end = -1000;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_rx.size() != 0 || exp_done.size() != 0 || o_busy !== 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", n < 3000, 1);
        repeat (3) @(negedge clk);
        chk("busy_low", o_busy, 0);
        chk("ovf_outstanding", exp_ovf.size(), 0);
    endtask

    // UART receiver: detect the start edge, sample every bit mid-way, score against the model
    initial forever begin
        @(negedge clk);
        if (!rst && o_serial === 1'b0) begin
            rx_s = edge_n;
            rx_ep = rst_epoch;
            repeat (CPB / 2) @(negedge clk);
            rx_start = o_serial;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                rx_d[i] = o_serial;
            end
            repeat (CPB) @(negedge clk);
            rx_stop = o_serial;
            if (rx_ep == rst_epoch) begin
                if (exp_rx.size() == 0) begin
                    n_err++;
                    $display("FAIL rx_unexpected: frame %02h at edge %0d, none expected", rx_d, rx_s);
                end else begin
                    rx_e = exp_rx.pop_front();
                    chk("rx_start_edge", rx_s, rx_e.s);
                    chk("rx_byte", rx_d, rx_e.b);
                    chk("rx_start_bit", rx_start, 0);
                    chk("rx_stop_bit", rx_stop, 1);
                end
            end
        end
    end

    // o_done must land exactly on the model's end-of-request edge
    always @(negedge clk) begin
        if (!rst && o_done === 1'b1) begin
            if (exp_done.size() == 0) begin
                n_err++;
                $display("FAIL done_unexpected: pulse at edge %0d, none expected", edge_n);
            end else chk("done_edge", edge_n, exp_done.pop_front());
        end
    end

    // o_overflow must match the model's dropped requests
    always @(negedge clk) begin
        if (!rst && o_overflow === 1'b1) begin
            if (exp_ovf.size() == 0) begin
                n_err++;
                $display("FAIL ovf_unexpected: pulse at edge %0d, none expected", edge_n);
            end else chk("ovf_edge", edge_n, exp_ovf.pop_front());
        end
    end

    // the line may only be low while a start or data bit is being driven
    always @(negedge clk) begin
        if (!rst && o_serial === 1'b0)
            assert (dut.state_q == S_START || dut.state_q == S_DATA)
            else begin
                n_err++;
                $display("FAIL line_idle: o_serial 0 in state %0d at edge %0d", dut.state_q, edge_n);
            end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_serial", o_serial, 1);
        chk("rst_done", o_done, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_ovf", o_overflow, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send(MODE_BYTE, $urandom, 8'h02);
        idle_en();
        wait_idle();
        send(MODE_WORD, 32'hDEADBEEF, 8'($urandom));
        idle_en();
        wait_idle();
        for (int i = 1; i <= 6; i++) send(MODE_BYTE, $urandom, 8'(i));
        idle_en();
        wait_idle();
        send(MODE_WORD, $urandom, 8'h00);
        for (int i = 0; i < 4; i++) send(MODE_BYTE, $urandom, 8'(8'h10 + i));
        idle_en();
        tgt = acc_pop[acc_pop.size() - 4];
        while (edge_n < tgt - 2) @(negedge clk);
        send(MODE_BYTE, $urandom, 8'h77);
        idle_en();
        wait_idle();
        send(MODE_BYTE, $urandom, 8'hA5);
        idle_en();
        tgt = acc_pop[acc_pop.size() - 1] + CPB + CPB / 2 + CPB;
        while (edge_n < tgt) @(negedge clk);
        #1 rst = 1'b1;
        rst_epoch++;
        model_reset();
        #1;
        chk("async_rst_serial", o_serial, 1);
        chk("async_rst_busy", o_busy, 0);
        chk("async_rst_done", o_done, 0);
        chk("async_rst_ovf", o_overflow, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (FRAME) @(negedge clk);
        send(MODE_BYTE, $urandom, 8'h3C);
        idle_en();
        wait_idle();
        for (int i = 0; i < 40; i++) begin
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 150) : $urandom_range(0, 2);
            send(1'($urandom_range(0, 1)), $urandom, 8'($urandom));
            if (gap != 0) begin
                idle_en();
                repeat (gap - 1) @(negedge clk);
            end
        end
        idle_en();
        wait_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
